bus_decoder: RTL
================

Name: bus_decoder

Overview:
- Single-master to NSLAVES-slave Wishbone (pipelined mode, with stall) address decoder and response router.
- Generalises the per-slave base/width address match to a parametrised slave table. Adds the following:
  - tracking of outstanding transactions;
  - a built-in error responder for unmapped addresses;
  - a response-timeout watchdog.
- Sits between the CPU bus master and the peripheral/memory slaves.

Parameters:
- NSLAVES, 4, number of slave ports (1..16).
- SLAVE_BASE, '0 (NSLAVES*32 bits packed), base address of slave i in bits [32*i+31:32*i]; bits below its width are zero.
- SLAVE_AW, {NSLAVES{6'd12}} (NSLAVES*6 bits packed), local address width of slave i (2..31).
- MAX_OUTSTANDING, 4, maximum number of accepted strobes still awaiting ack/err (1..15).
- TIMEOUT, 256, cycles allowed without a response while outstanding>0; 0 disables the watchdog.

Ports:
- clk  in  1  bus clock.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- m_addr  in  32  master address.
- m_data_m2s  in  32  master write data.
- m_cyc, m_stb, m_we  in  1 each  master cycle, strobe and write enable.
- m_sel  in  4  byte selects.
- m_data_s2m  out  32  read data routed to the master.
- m_ack, m_err, m_stall  out  1 each  responses and stall to the master.
- s_addr, s_data_m2s  out  32 each  broadcast from the master.
- s_we  out  1  broadcast from the master.
- s_sel  out  4  broadcast from the master.
- s_cyc, s_stb  out  NSLAVES each  one bit per slave.
- s_data_s2m  in  NSLAVES*32  slave read data, packed.
- s_ack, s_err, s_stall  in  NSLAVES each  slave responses.

Behaviour:
- Decode (combinational):
  - hit[i] = (m_addr[31:SLAVE_AW[i]] == SLAVE_BASE[i][31:SLAVE_AW[i]]).
  - sel_idx = lowest i with hit[i]; overlapping regions therefore resolve to the lowest index.
  - No hit means unmapped, idx = NSLAVES.
- State: cur_idx (locked target), cnt (outstanding count, 0..MAX_OUTSTANDING), tmr (watchdog), fsm.
- FSM states are IDLE, ACTIVE, UNMAPPED, ABORT. All registers reset asynchronously:
  - fsm=IDLE, cnt=0, tmr=0, cur_idx=0.
- Outputs during reset: s_cyc=0, s_stb=0, m_ack=0, m_err=0, m_stall=0, m_data_s2m=0.
- IDLE (cnt=0):
  - A master strobe to a mapped slave forwards stb the same cycle (zero added latency) and locks cur_idx=sel_idx.
  - Acceptance is m_stb & !m_stall. On acceptance, go to ACTIVE with cnt=1.
  - A strobe to an unmapped address is accepted and goes to UNMAPPED.
- ACTIVE:
  - s_cyc[cur_idx] = m_cyc; all other s_cyc bits are 0.
  - m_stall = s_stall[cur_idx] OR (cnt==MAX_OUTSTANDING) OR (sel_idx != cur_idx and m_stb).
  - A strobe to a different target is held off until cnt returns to 0. Responses are therefore never reordered across slaves.
  - cnt += accepted strobe; cnt -= (s_ack|s_err)[cur_idx]. Simultaneous accept and response leave cnt unchanged.
  - A response arriving when cnt=0 is dropped.
  - When cnt reaches 0 with no new accept, go to IDLE.
  - m_ack/m_err/m_data_s2m are taken combinationally from cur_idx.
- UNMAPPED:
  - m_err=1 for exactly one cycle (the cycle after acceptance), m_stall=1, then IDLE.
  - No slave sees cyc.
- Watchdog (TIMEOUT>0):
  - tmr clears on any response or when cnt=0; otherwise it increments in ACTIVE.
  - At tmr==TIMEOUT-1: assert m_err for one cycle, clear cnt, go to ABORT.
- ABORT:
  - s_cyc=0 and m_stall=1 for one cycle, then IDLE.
  - Late slave responses are ignored.
- Master drops m_cyc with cnt>0: cnt=0, s_cyc=0 on the same cycle, go to IDLE. Subsequent slave responses are not forwarded.
- m_ack and m_err are never both 1. If a slave asserts both, err wins.
- Whenever m_ack is 0, m_data_s2m=0.

Decomposition:
- bus_pkg holds:
  - BUS_DATAWIDTH, BUS_ADDRWIDTH, BUS_SELWIDTH;
  - the typedef of the fsm enum (IDLE, ACTIVE, UNMAPPED, ABORT);
  - the function addr_match(addr, base, aw).
- One sub-module: bus_addr_match (priority decode of NSLAVES hits into sel_idx plus an unmapped flag).

Test Plan:
- Reset mid-burst: rst=0 with cnt=3 -> all outputs 0 immediately (asynchronous). After release, the first strobe is accepted in IDLE.
- Routing: SLAVE_BASE[1]=0x1000_0000, AW=12. Read 0x1000_0040 -> s_stb[1]=1 in the same cycle. A slave ack 2 cycles later with data 0xDEADBEEF -> m_ack=1 and m_data_s2m=0xDEADBEEF.
- Pipelining: 5 back-to-back strobes to slave 0 with MAX_OUTSTANDING=4 and the slave not acking -> 4 accepted, m_stall=1 on the 5th. One ack -> 5th accepted the next cycle.
- Target switch: 2 outstanding to slave 0, then a strobe to slave 2 -> stalled until both acks return. Issued the cycle cnt reaches 0; s_cyc[0] drops.
- Unmapped: write to 0xF000_0000 with no matching region -> m_err=1 exactly one cycle after acceptance; s_cyc=0 throughout.
- Timeout: TIMEOUT=16, slave never responds -> m_err at cycle 16 after acceptance, then 1 cycle with s_cyc=0. A late s_ack is ignored and a new strobe is accepted.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared bus widths, decoder FSM states and the address-match helper.
package bus_pkg;
  localparam int BUS_DATAWIDTH = 32;
  localparam int BUS_ADDRWIDTH = 32;
  localparam int BUS_SELWIDTH = 4;
  typedef enum logic [1:0] {IDLE, ACTIVE, UNMAPPED, ABORT} bus_state_t;
  function automatic logic addr_match(input logic [BUS_ADDRWIDTH-1:0] addr, input logic [BUS_ADDRWIDTH-1:0] base, input logic [5:0] aw);
    return ((addr ^ base) & ({BUS_ADDRWIDTH{1'b1}} << aw)) == '0;
  endfunction
endpackage

// File: rtl/bus_addr_match.sv
// bus_addr_match: priority address decode, lowest matching slave wins; no match gives NSLAVES.
module bus_addr_match import bus_pkg::*; #(
  parameter int NSLAVES = 4,
  parameter logic [NSLAVES*32-1:0] SLAVE_BASE = '0,
  parameter logic [NSLAVES*6-1:0] SLAVE_AW = {NSLAVES{6'd12}},
  parameter int IW = 3
) (
  input  logic [BUS_ADDRWIDTH-1:0] addr,
  output logic [IW-1:0] sel_idx,
  output logic unmapped
);
  always_comb begin
    sel_idx = IW'(NSLAVES);
    for (int i = NSLAVES - 1; i >= 0; i--)
      if (addr_match(addr, SLAVE_BASE[32*i+:32], SLAVE_AW[6*i+:6])) sel_idx = IW'(i);
    unmapped = sel_idx == IW'(NSLAVES);
  end
endmodule

// File: rtl/bus_decoder.sv
// bus_decoder: pipelined Wishbone 1-to-N decoder with outstanding tracking, unmapped error and watchdog.
module bus_decoder import bus_pkg::*; #(
  parameter int NSLAVES = 4,
  parameter logic [NSLAVES*32-1:0] SLAVE_BASE = '0,
  parameter logic [NSLAVES*6-1:0] SLAVE_AW = {NSLAVES{6'd12}},
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic [BUS_ADDRWIDTH-1:0] m_addr,
  input  logic [BUS_DATAWIDTH-1:0] m_data_m2s,
  input  logic m_cyc,
  input  logic m_stb,
  input  logic m_we,
  input  logic [BUS_SELWIDTH-1:0] m_sel,
  output logic [BUS_DATAWIDTH-1:0] m_data_s2m,
  output logic m_ack,
  output logic m_err,
  output logic m_stall,
  output logic [BUS_ADDRWIDTH-1:0] s_addr,
  output logic [BUS_DATAWIDTH-1:0] s_data_m2s,
  output logic s_we,
  output logic [BUS_SELWIDTH-1:0] s_sel,
  output logic [NSLAVES-1:0] s_cyc,
  output logic [NSLAVES-1:0] s_stb,
  input  logic [NSLAVES*32-1:0] s_data_s2m,
  input  logic [NSLAVES-1:0] s_ack,
  input  logic [NSLAVES-1:0] s_err,
  input  logic [NSLAVES-1:0] s_stall
);
  localparam int IW = $clog2(NSLAVES + 1);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  bus_state_t fsm, fsm_n;
  logic [IW-1:0] cur_idx, cur_n, sel_idx, tgt;
  logic [CW-1:0] cnt, cnt_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [NSLAVES-1:0] oh;
  logic unmapped, req, same, full, to, rsp, acc, cyc_v, stb_v, t_stall, t_ack, t_err;
  logic [BUS_DATAWIDTH-1:0] t_data;
  bus_addr_match #(.NSLAVES(NSLAVES), .SLAVE_BASE(SLAVE_BASE), .SLAVE_AW(SLAVE_AW), .IW(IW)) u_match (
    .addr(m_addr), .sel_idx(sel_idx), .unmapped(unmapped));
  assign s_addr = m_addr;
  assign s_data_m2s = m_data_m2s;
  assign s_we = m_we;
  assign s_sel = m_sel;
  assign req = m_cyc & m_stb;
  assign tgt = fsm == IDLE ? sel_idx : cur_idx;
  assign s_cyc = oh & {NSLAVES{cyc_v & rst}};
  assign s_stb = oh & {NSLAVES{stb_v & rst}};
  always_comb begin
    oh = '0;
    t_stall = 1'b0;
    t_ack = 1'b0;
    t_err = 1'b0;
    t_data = '0;
    for (int i = 0; i < NSLAVES; i++)
      if (tgt == IW'(i)) begin
        oh[i] = 1'b1;
        t_stall = s_stall[i];
        t_ack = s_ack[i];
        t_err = s_err[i];
        t_data = s_data_s2m[32*i+:32];
      end
  end
  always_comb begin
    fsm_n = fsm;
    cur_n = cur_idx;
    cnt_n = cnt;
    tmr_n = '0;
    cyc_v = 1'b0;
    stb_v = 1'b0;
    acc = 1'b0;
    m_ack = 1'b0;
    m_err = 1'b0;
    m_stall = 1'b0;
    m_data_s2m = '0;
    same = sel_idx == cur_idx;
    full = cnt == CW'(MAX_OUTSTANDING);
    rsp = m_cyc & (t_ack | t_err);
    to = TIMEOUT > 0 && m_cyc && !rsp && tmr == TW'(TIMEOUT - 1);
    case (fsm)
      IDLE: begin
        cyc_v = req & !unmapped;
        stb_v = cyc_v;
        m_stall = cyc_v & t_stall;
        acc = req & !m_stall;
        if (acc) begin
          fsm_n = unmapped ? UNMAPPED : ACTIVE;
          cur_n = sel_idx;
          cnt_n = unmapped ? '0 : CW'(1);
        end
      end
      ACTIVE: begin
        cyc_v = m_cyc;
        m_stall = t_stall | full | (req & !same) | to;
        stb_v = req & same & !full & !to;
        acc = req & !m_stall;
        // a slave raising ack and err together is reported as an error
        m_err = m_cyc & (t_err | to);
        m_ack = m_cyc & t_ack & !t_err;
        m_data_s2m = m_ack ? t_data : '0;
        tmr_n = (m_cyc & !rsp & !to) ? tmr + TW'(1) : '0;
        cnt_n = (!m_cyc | to) ? '0 : cnt + CW'(acc) - CW'(rsp);
        fsm_n = to ? ABORT : (cnt_n == '0 ? IDLE : ACTIVE);
      end
      UNMAPPED: begin
        m_err = 1'b1;
        m_stall = 1'b1;
        fsm_n = IDLE;
      end
      default: begin
        m_stall = 1'b1;
        fsm_n = IDLE;
      end
    endcase
    if (!rst) begin
      m_ack = 1'b0;
      m_err = 1'b0;
      m_stall = 1'b0;
      m_data_s2m = '0;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      fsm <= IDLE;
      cur_idx <= '0;
      cnt <= '0;
      tmr <= '0;
    end else begin
      fsm <= fsm_n;
      cur_idx <= cur_n;
      cnt <= cnt_n;
      tmr <= tmr_n;
    end
endmodule
